// File: rtl/gppcu_alu_seq.sv
// gppcu_alu_seq -- instruction sequencer in front of the GPPCU combinational ALU.
//
// This block accepts one 32-bit instruction per handshake. It reads operands from a
// private 16 x BW register file and presents them to the ALU together with the stored
// carry flag. At the end of EXEC it writes the ALU result and the NZCV flags back.
// Each instruction takes 3 cycles: IDLE (accept), EXEC, then DONE.
//
// Instruction word: [31:28] op, [27:24] rd, [23:20] ra, [19:16] rb, [15:0] imm
//
// Ports
//   iCLK, iRST         clock; synchronous active-high reset
//   iINSTR, iVALID     instruction word and valid
//   oREADY             high in IDLE only
//   oALU_A/B/C/OP      operands, carry-in and opcode driven to the ALU
//   iALU_Q, iALU_N/Z/C/V  ALU result and flags, sampled at the end of EXEC
//   oDONE              one-cycle retire pulse (DONE state)
//   oRESULT            last written result
//   oFLAGS             {N,Z,C,V}
//   oERR               one-cycle pulse in the cycle after a reserved opcode is accepted
//   iDBG_SEL/oDBG_DATA combinational register-file read port
//   oRETIRED           retired-instruction count (0 unless GPPCU_RETIRE_CNT_EN)
//   oDBG_STATE         FSM state (0 IDLE, 1 EXEC, 2 DONE), debug only
//
// Optional feature: define GPPCU_RETIRE_CNT_EN to build the 32-bit retire counter.
//
// Handshake: an instruction transfers on a rising edge where iVALID && oREADY.
// The sender must hold iINSTR stable while iVALID is high and oREADY is low.
// iVALID seen while oREADY is low is ignored.

module gppcu_alu_seq #(
  parameter int BW = 32
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [31:0]   iINSTR,
  input  logic          iVALID,
  output logic          oREADY,
  output logic [BW-1:0] oALU_A,
  output logic [BW-1:0] oALU_B,
  output logic          oALU_C,
  output logic [3:0]    oALU_OP,
  input  logic [BW-1:0] iALU_Q,
  input  logic          iALU_V,
  input  logic          iALU_C,
  input  logic          iALU_N,
  input  logic          iALU_Z,
  output logic          oDONE,
  output logic [BW-1:0] oRESULT,
  output logic [3:0]    oFLAGS,
  output logic          oERR,
  input  logic [3:0]    iDBG_SEL,
  output logic [BW-1:0] oDBG_DATA,
  output logic [31:0]   oRETIRED,
  output logic [1:0]    oDBG_STATE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADI = 4'd8;
  localparam logic [3:0] OP_SBI = 4'd9;
  localparam logic [3:0] OP_MVI = 4'd10;

  logic [1:0]    state_q, state_d;
  logic [3:0]    op_q;
  logic [3:0]    rd_q;
  logic [BW-1:0] a_q, b_q;
  logic          alu_c_q;
  logic [3:0]    flags_q;
  logic [BW-1:0] result_q;
  logic          err_q;
  logic [BW-1:0] regs_q [16];

  // Instruction fields
  logic [3:0]    in_op, in_rd, in_ra, in_rb;
  logic [15:0]   in_imm;
  logic          in_rsvd, in_use_imm, accept;
  logic [BW-1:0] in_b;

  assign in_op      = iINSTR[31:28];
  assign in_rd      = iINSTR[27:24];
  assign in_ra      = iINSTR[23:20];
  assign in_rb      = iINSTR[19:16];
  assign in_imm     = iINSTR[15:0];
  assign in_rsvd    = (in_op == 4'd14) || (in_op == 4'd15);
  assign in_use_imm = (in_op == OP_ADI) || (in_op == OP_SBI) || (in_op == OP_MVI);
  assign in_b       = in_use_imm ? {{(BW-16){1'b0}}, in_imm} : regs_q[in_rb];
  assign accept     = iVALID && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      rd_q     <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      alu_c_q  <= 1'b0;
      flags_q  <= 4'd0;
      result_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (accept) begin
        // The carry flag is stable while IDLE, so latching it here gives the
        // value of flag C during EXEC and keeps oALU_C held afterwards.
        alu_c_q <= flags_q[1];
        if (in_rsvd) begin
          // Reserved opcodes travel through EXEC/DONE as a NOP.
          op_q  <= OP_NOP;
          err_q <= 1'b1;
        end else begin
          op_q <= in_op;
          rd_q <= in_rd;
          a_q  <= regs_q[in_ra];
          b_q  <= in_b;
        end
      end
      if (state_q == S_EXEC && op_q != OP_NOP) begin
        regs_q[rd_q] <= iALU_Q;
        flags_q      <= {iALU_N, iALU_Z, iALU_C, iALU_V};
        result_q     <= iALU_Q;
      end
    end
  end

  assign oREADY     = (state_q == S_IDLE);
  assign oDONE      = (state_q == S_DONE);
  assign oERR       = err_q;
  assign oALU_A     = a_q;
  assign oALU_B     = b_q;
  assign oALU_C     = alu_c_q;
  assign oALU_OP    = (state_q == S_IDLE) ? OP_NOP : op_q;
  assign oRESULT    = result_q;
  assign oFLAGS     = flags_q;
  assign oDBG_DATA  = regs_q[iDBG_SEL];
  assign oDBG_STATE = state_q;

`ifdef GPPCU_RETIRE_CNT_EN
  logic [31:0] retired_q;

  // Wraps naturally from 0xFFFFFFFF to 0.
  always_ff @(posedge iCLK) begin
    if (iRST) retired_q <= 32'd0;
    else if (state_q == S_DONE) retired_q <= retired_q + 32'd1;
  end

  assign oRETIRED = retired_q;
`else
  assign oRETIRED = 32'd0;
`endif

endmodule
